oflow_mem_buffer_mc: RTL and testbench
======================================

OFLOW_MEM_BUFFER_MC -- requirements
Module: oflow_mem_buffer_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bits per bbox word.
REQ-002 Parameter NUM_CH, default 2: bbox words moved per beat (lanes).
REQ-003 Parameter MAX_BBOX, default 32: bbox capacity per frame slot; SHALL be a multiple of NUM_CH; BEATS = MAX_BBOX/NUM_CH.
REQ-004 Parameter MAX_HIST, default 5: number of history frame slots (ring).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset_N  in  1  asynchronous, active-high reset (1 = reset asserted).
REQ-007 start_write  in  1  one-cycle pulse, begin capture of current frame.
REQ-008 start_read  in  1  one-cycle pulse, begin history read-out.
REQ-009 wr_valid  in  1  write beat present on wr_data.
REQ-010 wr_data  in  NUM_CH*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 num_of_bbox_in_frame  in  $clog2(MAX_BBOX+1)  bbox count of current frame; sampled on start_write and start_read.
REQ-012 num_of_history_frames  in  $clog2(MAX_HIST+1)  fallback depth; sampled on start_read.
REQ-013 read_new_line  in  1  similarity metric finished one line; release next line.
REQ-014 rd_ready  in  1  consumer accepts rd_data.
REQ-015 rd_valid  out  1  rd_data valid.
REQ-016 rd_data  out  NUM_CH*DATA_WIDTH  history beat; invalid lanes forced to 0.
REQ-017 rd_lane_valid  out  NUM_CH  per-lane valid mask.
REQ-018 counter_of_history_frame_to_interface  out  $clog2(MAX_HIST+1)  age k of frame on rd_data (0 = newest).
REQ-019 done_write, done_read  out  1 each  one-cycle completion pulses.
REQ-020 busy  out  1  state != IDLE.
REQ-021 err_collision  out  1  one-cycle pulse on rejected start.

Function
REQ-022 Storage: flop array MAX_HIST x BEATS entries of NUM_CH*DATA_WIDTH, plus per-slot stored bbox count; rd_data driven combinationally from array (zero latency).
REQ-023 State machine: IDLE, WRITE, RD_STREAM, RD_WAIT_LINE; start_* honoured only in IDLE.
REQ-024 IDLE + start_write: latch N = num_of_bbox_in_frame, beat count W = ceil(N/NUM_CH), go WRITE; N = 0 -> done_write next cycle, stay IDLE.
REQ-025 WRITE: each wr_valid cycle writes beat b (0..W-1) into slot wr_slot; after beat W-1 is written, done_write pulses the next cycle, slot count := N, wr_slot := (wr_slot+1) mod MAX_HIST, frames_stored := min(frames_stored+1, MAX_HIST), return IDLE.
REQ-026 N = 0 frames still occupy a slot (count 0) and advance wr_slot.
REQ-027 IDLE + start_read: latch L = num_of_bbox_in_frame lines, H = min(num_of_history_frames, frames_stored); L = 0 or H = 0 -> done_read next cycle, stay IDLE; else go RD_STREAM, line = 0, k = 0, beat = 0.
REQ-028 RD_STREAM: frame k read from slot (wr_slot-1-k) mod MAX_HIST; beats 0..ceil(cnt/NUM_CH)-1; rd_valid = 1; lane i valid iff beat*NUM_CH+i < cnt.
REQ-029 Beat advances only on rd_valid & rd_ready; rd_data/rd_valid SHALL hold stable while rd_ready = 0.
REQ-030 Frame with cnt = 0 is skipped with no beat emitted (k increments in one cycle, rd_valid = 0 that cycle).
REQ-031 After last beat of frame H-1: line+1 == L -> done_read pulse next cycle, IDLE; else RD_WAIT_LINE.
REQ-032 RD_WAIT_LINE: rd_valid = 0; read_new_line -> line+1, k = 0, beat = 0, RD_STREAM; read_new_line in other states ignored.
REQ-033 start_write and start_read same IDLE cycle: write wins, err_collision pulses; any start_* outside IDLE ignored with err_collision pulse.
REQ-034 Ring wrap: oldest slot overwritten once frames_stored = MAX_HIST; k never exceeds H-1.

Reset
REQ-035 reset_N asserted: state IDLE, wr_slot = 0, frames_stored = 0, all counters 0, all outputs 0 (rd_data 0, rd_lane_valid 0); array contents need not be cleared.
REQ-036 Reset mid-WRITE or mid-read aborts with no done pulse; partially written frame is not counted.

Verification (NUM_CH=2, MAX_BBOX=8, MAX_HIST=3, DATA_WIDTH=32)
REQ-037 Write N=5 (3 beats) then start_read L=1, history=1 -> 3 beats, last beat rd_lane_valid=2'b01, upper lane 0, done_read one cycle after last handshake.
REQ-038 Write 4 frames (N=2,4,6,8) then read history=3 -> frames ordered N=8,6,4 with k=0,1,2; N=2 frame overwritten.
REQ-039 L=3 read with rd_ready toggled 50%: data stable while stalled, RD_WAIT_LINE held until each read_new_line, exactly one done_read.
REQ-040 start_read with frames_stored=0 -> done_read next cycle, rd_valid never high; start_write+start_read same cycle -> WRITE entered, err_collision pulse.
REQ-041 reset_N asserted mid-beat 2 of write -> IDLE, frames_stored=0, no done_write; subsequent read returns done_read immediately.

Source files
------------

// File: rtl/oflow_mem_buffer_mc_if.sv
// Bus bundle for the optical-flow bbox history buffer: frame capture
// handshake, history read-out stream and status pulses.
interface oflow_mem_buffer_mc_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int MAX_BBOX   = 32,
  parameter int MAX_HIST   = 5
);
  localparam int CW = $clog2(MAX_BBOX + 1);
  localparam int HW = $clog2(MAX_HIST + 1);

  logic                         start_write;
  logic                         start_read;
  logic                         wr_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] wr_data;
  logic [CW-1:0]                num_of_bbox_in_frame;
  logic [HW-1:0]                num_of_history_frames;
  logic                         read_new_line;
  logic                         rd_ready;
  logic                         rd_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] rd_data;
  logic [NUM_CH-1:0]            rd_lane_valid;
  logic [HW-1:0]                counter_of_history_frame_to_interface;
  logic                         done_write;
  logic                         done_read;
  logic                         busy;
  logic                         err_collision;

  modport master (
    output start_write, start_read, wr_valid, wr_data, num_of_bbox_in_frame,
           num_of_history_frames, read_new_line, rd_ready,
    input  rd_valid, rd_data, rd_lane_valid, counter_of_history_frame_to_interface,
           done_write, done_read, busy, err_collision
  );

  modport slave (
    input  start_write, start_read, wr_valid, wr_data, num_of_bbox_in_frame,
           num_of_history_frames, read_new_line, rd_ready,
    output rd_valid, rd_data, rd_lane_valid, counter_of_history_frame_to_interface,
           done_write, done_read, busy, err_collision
  );
endinterface

// File: rtl/oflow_mem_buffer_mc.sv
// Multi-lane bbox history buffer: captures one frame of bboxes per write
// into a ring of MAX_HIST slots, then replays the newest H frames once per
// similarity-metric line, newest first, with a zero-latency read path.
module oflow_mem_buffer_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int MAX_BBOX   = 32,
  parameter int MAX_HIST   = 5
) (
  input logic                  clk,
  input logic                  reset_N,
  oflow_mem_buffer_mc_if.slave bus
);
  localparam int BEATS = MAX_BBOX / NUM_CH;
  localparam int CW    = $clog2(MAX_BBOX + 1);
  localparam int HW    = $clog2(MAX_HIST + 1);
  localparam int SW    = (MAX_HIST > 1) ? $clog2(MAX_HIST) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, RD_STREAM, RD_WAIT_LINE} state_t;

  state_t        state;
  logic [CW-1:0] n_lat;
  logic [CW-1:0] lines;
  logic [CW-1:0] line;
  logic [HW-1:0] h_lat;
  logic [HW-1:0] k;
  logic [HW-1:0] frames_stored;
  logic [SW-1:0] wr_slot;
  logic [BW-1:0] wbeat;
  logic [BW-1:0] rbeat;
  logic          done_write_r;
  logic          done_read_r;
  logic          err_r;

  logic [NUM_CH*DATA_WIDTH-1:0] mem [MAX_HIST][BEATS];
  logic [CW-1:0]                slot_cnt [MAX_HIST];

  int                           rd_idx;
  int                           rd_beats;
  int                           wr_beats;
  logic [SW-1:0]                rd_slot;
  logic [CW-1:0]                rd_cnt;
  logic                         rd_valid_c;
  logic                         beat_last;
  logic                         frame_last;
  logic                         wr_last;
  logic                         wr_commit;
  logic [CW-1:0]                commit_cnt;
  logic [HW-1:0]                h_next;
  logic [NUM_CH-1:0]            lane_mask;
  logic [NUM_CH*DATA_WIDTH-1:0] rd_data_c;

  // Address the frame of age k, derive lane masks and the end-of-beat/frame flags.
  always_comb begin
    rd_idx = int'(wr_slot) + MAX_HIST - 1 - int'(k);
    if (rd_idx >= MAX_HIST) rd_idx = rd_idx - MAX_HIST;
    rd_slot    = SW'(rd_idx);
    rd_cnt     = slot_cnt[rd_slot];
    rd_beats   = (int'(rd_cnt) + NUM_CH - 1) / NUM_CH;
    beat_last  = (int'(rbeat) == rd_beats - 1);
    frame_last = (k == h_lat - 1'b1);
    rd_valid_c = (state == RD_STREAM) && (rd_cnt != '0);
    wr_beats   = (int'(n_lat) + NUM_CH - 1) / NUM_CH;
    wr_last    = (int'(wbeat) == wr_beats - 1);
    wr_commit  = ((state == IDLE) && bus.start_write && (bus.num_of_bbox_in_frame == '0)) ||
                 ((state == WRITE) && bus.wr_valid && wr_last);
    commit_cnt = (state == IDLE) ? '0 : n_lat;
    h_next     = (bus.num_of_history_frames < frames_stored) ? bus.num_of_history_frames
                                                             : frames_stored;
    lane_mask  = '0;
    rd_data_c  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lane_mask[i] = rd_valid_c && ((int'(rbeat) * NUM_CH + i) < int'(rd_cnt));
      if (lane_mask[i])
        rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_slot][rbeat][i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Storage array and per-slot bbox counts; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if ((state == WRITE) && bus.wr_valid) mem[wr_slot][wbeat] <= bus.wr_data;
    if (wr_commit) slot_cnt[wr_slot] <= commit_cnt;
  end

  // Control FSM: capture, streamed read-out, per-line wait and status pulses.
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      state         <= IDLE;
      n_lat         <= '0;
      lines         <= '0;
      line          <= '0;
      h_lat         <= '0;
      k             <= '0;
      frames_stored <= '0;
      wr_slot       <= '0;
      wbeat         <= '0;
      rbeat         <= '0;
      done_write_r  <= 1'b0;
      done_read_r   <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      done_write_r <= 1'b0;
      done_read_r  <= 1'b0;
      err_r        <= (state != IDLE) && (bus.start_write || bus.start_read);
      if (wr_commit) begin
        wr_slot      <= (int'(wr_slot) == MAX_HIST - 1) ? '0 : wr_slot + 1'b1;
        done_write_r <= 1'b1;
        if (frames_stored != HW'(MAX_HIST)) frames_stored <= frames_stored + 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.start_write) begin
            err_r <= bus.start_read;
            n_lat <= bus.num_of_bbox_in_frame;
            wbeat <= '0;
            if (bus.num_of_bbox_in_frame != '0) state <= WRITE;
          end else if (bus.start_read) begin
            lines <= bus.num_of_bbox_in_frame;
            h_lat <= h_next;
            line  <= '0;
            k     <= '0;
            rbeat <= '0;
            if ((bus.num_of_bbox_in_frame == '0) || (h_next == '0)) done_read_r <= 1'b1;
            else state <= RD_STREAM;
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            if (wr_last) state <= IDLE;
            else wbeat <= wbeat + 1'b1;
          end
        end
        RD_STREAM: begin
          // Empty frames fall through in one cycle without emitting a beat.
          if ((rd_cnt == '0) || (bus.rd_ready && beat_last)) begin
            rbeat <= '0;
            if (frame_last) begin
              if (line + 1'b1 == lines) begin
                done_read_r <= 1'b1;
                state       <= IDLE;
              end else begin
                state <= RD_WAIT_LINE;
              end
            end else begin
              k <= k + 1'b1;
            end
          end else if (bus.rd_ready) begin
            rbeat <= rbeat + 1'b1;
          end
        end
        RD_WAIT_LINE: begin
          if (bus.read_new_line) begin
            line  <= line + 1'b1;
            k     <= '0;
            rbeat <= '0;
            state <= RD_STREAM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_valid                              = rd_valid_c;
  assign bus.rd_data                               = rd_data_c;
  assign bus.rd_lane_valid                         = lane_mask;
  assign bus.counter_of_history_frame_to_interface = k;
  assign bus.done_write                            = done_write_r;
  assign bus.done_read                             = done_read_r;
  assign bus.busy                                  = (state != IDLE);
  assign bus.err_collision                         = err_r;
endmodule

// File: tb/tb_oflow_mem_buffer_mc.sv
// Directed bench for the bbox history buffer (2 lanes, 8 bboxes, 3 slots).
module tb_oflow_mem_buffer_mc;
  logic clk;
  logic reset_N;
  int   errors = 0;
  int   checks = 0;

  oflow_mem_buffer_mc_if #(.DATA_WIDTH(32), .NUM_CH(2), .MAX_BBOX(8), .MAX_HIST(3)) bus ();

  oflow_mem_buffer_mc #(.DATA_WIDTH(32), .NUM_CH(2), .MAX_BBOX(8), .MAX_HIST(3)) dut (
    .clk     (clk),
    .reset_N (reset_N),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int fid, input int b, input int lane);
    return 32'hA000_0000 | (32'(fid) << 16) | (32'(b) << 8) | 32'(lane);
  endfunction

  // Expected read beat: lanes beyond the frame's bbox count read as zero.
  function automatic logic [63:0] exp_data(input int fid, input int n, input int b);
    logic [63:0] d;
    d = '0;
    if (2*b < n)     d[31:0]  = pat(fid, b, 0);
    if (2*b + 1 < n) d[63:32] = pat(fid, b, 1);
    return d;
  endfunction

  function automatic logic [1:0] exp_mask(input int n, input int b);
    logic [1:0] m;
    m[0] = (2*b < n);
    m[1] = (2*b + 1 < n);
    return m;
  endfunction

  task automatic write_frame(input int fid, input int n);
    bus.num_of_bbox_in_frame = 4'(n);
    bus.start_write = 1'b1;
    tick;
    bus.start_write = 1'b0;
    if (n > 0) begin
      chk($sformatf("wr_busy_f%0d", fid), bus.busy, 1);
      for (int b = 0; b < (n + 1) / 2; b++) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = {pat(fid, b, 1), pat(fid, b, 0)};
        tick;
      end
      bus.wr_valid = 1'b0;
    end
    chk($sformatf("wr_done_f%0d", fid), bus.done_write, 1);
    chk($sformatf("wr_idle_f%0d", fid), bus.busy, 0);
    tick;
    chk($sformatf("wr_done_clr_f%0d", fid), bus.done_write, 0);
  endtask

  task automatic start_rd(input int l, input int h);
    bus.num_of_bbox_in_frame  = 4'(l);
    bus.num_of_history_frames = 2'(h);
    bus.start_read = 1'b1;
    tick;
    bus.start_read = 1'b0;
  endtask

  task automatic read_frame(input int fid, input int n, input int k, input bit stall);
    for (int b = 0; b < (n + 1) / 2; b++) begin
      if (stall) begin
        bus.rd_ready = 1'b0;
        chk($sformatf("pre_stall_f%0d_b%0d", fid, b), bus.rd_data, exp_data(fid, n, b));
        tick;
      end
      bus.rd_ready = 1'b1;
      chk($sformatf("rvalid_f%0d_b%0d", fid, b), bus.rd_valid, 1);
      chk($sformatf("rdata_f%0d_b%0d", fid, b), bus.rd_data, exp_data(fid, n, b));
      chk($sformatf("rmask_f%0d_b%0d", fid, b), bus.rd_lane_valid, exp_mask(n, b));
      chk($sformatf("rk_f%0d_b%0d", fid, b), bus.counter_of_history_frame_to_interface, k);
      tick;
    end
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    reset_N                   = 1'b1;
    bus.start_write           = 1'b0;
    bus.start_read            = 1'b0;
    bus.wr_valid              = 1'b0;
    bus.wr_data               = '0;
    bus.num_of_bbox_in_frame  = '0;
    bus.num_of_history_frames = '0;
    bus.read_new_line         = 1'b0;
    bus.rd_ready              = 1'b0;
    tick;
    tick;
    chk("rst_busy", bus.busy, 0);
    chk("rst_rvalid", bus.rd_valid, 0);
    chk("rst_rdata", bus.rd_data, 64'h0);
    chk("rst_mask", bus.rd_lane_valid, 0);
    chk("rst_k", bus.counter_of_history_frame_to_interface, 0);
    chk("rst_dones", {bus.done_write, bus.done_read, bus.err_collision}, 0);
    reset_N = 1'b0;
    tick;

    // Read with an empty history completes immediately.
    start_rd(1, 3);
    chk("empty_done", bus.done_read, 1);
    chk("empty_rvalid", bus.rd_valid, 0);
    chk("empty_busy", bus.busy, 0);
    tick;
    chk("empty_done_clr", bus.done_read, 0);

    // Five bboxes in three beats, single-frame read-out.
    write_frame(1, 5);
    start_rd(1, 1);
    read_frame(1, 5, 0, 1'b0);
    chk("n5_done", bus.done_read, 1);
    chk("n5_rvalid_off", bus.rd_valid, 0);
    tick;
    chk("n5_done_clr", bus.done_read, 0);
    // Direct replay of the final partial beat through a fresh read.
    start_rd(1, 1);
    bus.rd_ready = 1'b1;
    tick;
    tick;
    chk("n5_last_mask", bus.rd_lane_valid, 2'b01);
    chk("n5_last_upper", bus.rd_data[63:32], 32'h0);
    chk("n5_last_lower", bus.rd_data[31:0], 32'hA001_0200);
    tick;
    bus.rd_ready = 1'b0;
    chk("n5_done2", bus.done_read, 1);
    tick;

    // Ring wrap: frame 2 is overwritten, newest first on read.
    write_frame(2, 2);
    write_frame(3, 4);
    write_frame(4, 6);
    write_frame(5, 8);
    start_rd(1, 3);
    read_frame(5, 8, 0, 1'b0);
    read_frame(4, 6, 1, 1'b0);
    read_frame(3, 4, 2, 1'b0);
    chk("ring_done", bus.done_read, 1);
    tick;

    // Three lines with a stalling consumer and line-release waits.
    start_rd(3, 2);
    for (int l = 0; l < 3; l++) begin
      read_frame(5, 8, 0, 1'b1);
      read_frame(4, 6, 1, 1'b1);
      if (l < 2) begin
        chk($sformatf("wait_rvalid_l%0d", l), bus.rd_valid, 0);
        chk($sformatf("wait_busy_l%0d", l), bus.busy, 1);
        chk($sformatf("wait_nodone_l%0d", l), bus.done_read, 0);
        tick;
        chk($sformatf("wait_hold_l%0d", l), {bus.busy, bus.rd_valid, bus.done_read}, 3'b100);
        bus.read_new_line = 1'b1;
        tick;
        bus.read_new_line = 1'b0;
      end
    end
    chk("l3_done", bus.done_read, 1);
    chk("l3_idle", bus.busy, 0);
    tick;
    chk("l3_done_once", bus.done_read, 0);

    // Simultaneous starts: write wins; a start inside WRITE is rejected.
    bus.num_of_bbox_in_frame = 4'd2;
    bus.num_of_history_frames = 2'd1;
    bus.start_write = 1'b1;
    bus.start_read  = 1'b1;
    tick;
    bus.start_write = 1'b0;
    chk("coll_err", bus.err_collision, 1);
    chk("coll_busy", bus.busy, 1);
    tick;
    bus.start_read = 1'b0;
    chk("inwr_err", bus.err_collision, 1);
    chk("inwr_busy", bus.busy, 1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = {pat(6, 0, 1), pat(6, 0, 0)};
    tick;
    bus.wr_valid = 1'b0;
    chk("coll_wr_done", bus.done_write, 1);
    chk("coll_err_clr", bus.err_collision, 0);
    tick;

    // Empty frame occupies a slot and is skipped on read.
    write_frame(7, 0);
    start_rd(1, 2);
    chk("skip_rvalid", bus.rd_valid, 0);
    chk("skip_k0", bus.counter_of_history_frame_to_interface, 0);
    chk("skip_busy", bus.busy, 1);
    tick;
    read_frame(6, 2, 1, 1'b0);
    chk("skip_done", bus.done_read, 1);
    tick;

    // Reset during the third write beat discards the frame and the history.
    bus.num_of_bbox_in_frame = 4'd8;
    bus.start_write = 1'b1;
    tick;
    bus.start_write = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = {pat(8, b, 1), pat(8, b, 0)};
      tick;
    end
    bus.wr_data = {pat(8, 2, 1), pat(8, 2, 0)};
    reset_N = 1'b1;
    bus.wr_valid = 1'b0;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_nodone", bus.done_write, 0);
    tick;
    reset_N = 1'b0;
    tick;
    chk("mrst_nodone2", bus.done_write, 0);
    start_rd(1, 3);
    chk("mrst_rd_done", bus.done_read, 1);
    chk("mrst_rd_rvalid", bus.rd_valid, 0);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
